// File: rtl/cache_line_buffer_if.sv
// Controller-side bundle for the cache line buffer: strobes, data sources, miss addresses
// and the index/data/address outputs returned to L1 and main memory.
interface cache_line_buffer_if #(
  parameter int unsigned WORDS  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned IDX_W = $clog2(WORDS);

  logic              clr;
  logic              we_cl;
  logic              next_cl;
  logic [1:0]        sel_cl;
  logic [DATA_W-1:0] mm_rdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic [ADDR_W-1:0] imem_miss_addr;
  logic [ADDR_W-1:0] dmem_miss_addr;
  logic [ADDR_W-1:0] dmem_victim_addr;
  logic              full_cl;
  logic [IDX_W-1:0]  cl_idx;
  logic [DATA_W-1:0] cl_rdata;
  logic [ADDR_W-1:0] mm_addr;

  modport master (
    output clr, we_cl, next_cl, sel_cl, mm_rdata, dmem_rdata,
           imem_miss_addr, dmem_miss_addr, dmem_victim_addr,
    input  full_cl, cl_idx, cl_rdata, mm_addr
  );

  modport slave (
    input  clr, we_cl, next_cl, sel_cl, mm_rdata, dmem_rdata,
           imem_miss_addr, dmem_miss_addr, dmem_victim_addr,
    output full_cl, cl_idx, cl_rdata, mm_addr
  );
endinterface

// File: rtl/cache_line_buffer.sv
// Single cache-line staging buffer between L1 and main memory: word index counter,
// line registers, source mux and per-word main-memory address generation.
module cache_line_buffer #(
  parameter int unsigned WORDS  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input logic               clk,
  input logic               reset,
  cache_line_buffer_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(WORDS);
  localparam int unsigned HI_W  = ADDR_W - IDX_W - 2;

  typedef enum logic [1:0] {
    SEL_IMEM = 2'b00,
    SEL_DMEM = 2'b01,
    SEL_WB   = 2'b10,
    SEL_RSVD = 2'b11
  } sel_e;

  sel_e              sel;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] line [WORDS];
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [HI_W-1:0]   base_hi;

  assign sel = sel_e'(bus.sel_cl);

  always_comb begin
    wr_en   = bus.we_cl;
    wr_data = bus.mm_rdata;
    base_hi = '0;
    case (sel)
      SEL_IMEM: base_hi = bus.imem_miss_addr[ADDR_W-1:IDX_W+2];
      SEL_DMEM: base_hi = bus.dmem_miss_addr[ADDR_W-1:IDX_W+2];
      SEL_WB: begin
        base_hi = bus.dmem_victim_addr[ADDR_W-1:IDX_W+2];
        wr_data = bus.dmem_rdata;
      end
      default: wr_en = 1'b0;
    endcase
  end

  // Write uses the pre-increment index; idx wraps naturally since WORDS is a power of two.
  always_ff @(posedge clk) begin
    if (reset || bus.clr) begin
      idx <= '0;
      for (int unsigned i = 0; i < WORDS; i++) line[i] <= '0;
    end else begin
      if (wr_en) line[idx] <= wr_data;
      if (bus.next_cl) idx <= idx + 1'b1;
    end
  end

  assign bus.full_cl  = (idx == IDX_W'(WORDS - 1));
  assign bus.cl_idx   = idx;
  assign bus.cl_rdata = line[idx];
  assign bus.mm_addr  = (sel == SEL_RSVD) ? '0 : {base_hi, idx, 2'b00};
endmodule

// File: tb/tb_cache_line_buffer.sv
// Directed self-checking bench for cache_line_buffer with WORDS=4, 32-bit data and address.
module tb_cache_line_buffer;
  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  cache_line_buffer_if #(.WORDS(4), .DATA_W(32), .ADDR_W(32)) bus ();

  cache_line_buffer #(.WORDS(4), .DATA_W(32), .ADDR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walks all four words without writing; leaves idx where it started.
  task automatic read_line(input string tag, input logic [31:0] b, input logic [31:0] step);
    bus.we_cl   = 1'b0;
    bus.next_cl = 1'b1;
    bus.sel_cl  = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk({tag, "_rdata"}, bus.cl_rdata, b + step * 32'(i));
      tick();
    end
    bus.next_cl = 1'b0;
  endtask

  initial begin
    int k;
    n_assert = 0;
    n_fail   = 0;
    bus.clr = 1'b0; bus.we_cl = 1'b1; bus.next_cl = 1'b1; bus.sel_cl = 2'b00;
    bus.mm_rdata = 32'h55; bus.dmem_rdata = 32'h66;
    bus.imem_miss_addr = 32'h0000_1234; bus.dmem_miss_addr = 32'h2000_0018;
    bus.dmem_victim_addr = 32'h0000_0040;

    // Reset held two cycles with strobes active
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0; bus.we_cl = 1'b0; bus.next_cl = 1'b0;
    #1;
    chk("rst_idx", 32'(bus.cl_idx), 32'd0);
    chk("rst_full", 32'(bus.full_cl), 32'd0);
    chk("rst_rdata", bus.cl_rdata, 32'd0);
    chk("rst_mm_addr", bus.mm_addr, 32'h0000_1230);
    read_line("rst_line", 32'd0, 32'd0);

    // Imem fetch: next_cl pulsed on cycles 2,5,6,9, we_cl held high
    bus.sel_cl = 2'b00; bus.we_cl = 1'b1;
    k = 0;
    for (int c = 1; c <= 9; c++) begin
      bus.next_cl  = (c == 2 || c == 5 || c == 6 || c == 9);
      bus.mm_rdata = 32'hA0 + 32'(k);
      #1;
      chk("fetch_idx", 32'(bus.cl_idx), 32'(k));
      chk("fetch_mm_addr", bus.mm_addr, 32'h1230 + 32'(4 * k));
      chk("fetch_full", 32'(bus.full_cl), 32'(k == 3));
      chk("fetch_rdata", bus.cl_rdata, (c == 1 || c == 3 || c == 6 || c == 7) ? 32'd0 : 32'hA0 + 32'(k));
      tick();
      if (bus.next_cl) k++;
    end
    bus.we_cl = 1'b0; bus.next_cl = 1'b0;
    #1;
    chk("fetch_wrap_idx", 32'(bus.cl_idx), 32'd0);
    read_line("fetch_line", 32'hA0, 32'd1);

    // Writeback from dmem, read-before-write shows old fetched word
    bus.sel_cl = 2'b10; bus.we_cl = 1'b1; bus.next_cl = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.dmem_rdata = 32'hD0 + 32'(i);
      #1;
      chk("wb_mm_addr", bus.mm_addr, 32'h40 + 32'(4 * i));
      chk("wb_full", 32'(bus.full_cl), 32'(i == 3));
      chk("wb_old_rdata", bus.cl_rdata, 32'hA0 + 32'(i));
      tick();
    end
    #1;
    chk("wb_wrap_idx", 32'(bus.cl_idx), 32'd0);
    read_line("wb_line", 32'hD0, 32'd1);

    // Clear wins over simultaneous write and advance at idx=2
    bus.we_cl = 1'b0; bus.next_cl = 1'b1;
    tick(); tick();
    chk("clr_pre_idx", 32'(bus.cl_idx), 32'd2);
    bus.clr = 1'b1; bus.we_cl = 1'b1; bus.sel_cl = 2'b01; bus.mm_rdata = 32'h77;
    tick();
    bus.clr = 1'b0; bus.we_cl = 1'b0; bus.next_cl = 1'b0;
    #1;
    chk("clr_idx", 32'(bus.cl_idx), 32'd0);
    read_line("clr_line", 32'd0, 32'd0);

    // Dmem fill, then reserved select must not write but still advance
    bus.sel_cl = 2'b01; bus.we_cl = 1'b1; bus.next_cl = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.mm_rdata = 32'hB0 + 32'(i);
      #1;
      chk("dfill_mm_addr", bus.mm_addr, 32'h2000_0010 + 32'(4 * i));
      tick();
    end
    bus.sel_cl = 2'b11; bus.mm_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rsvd_mm_addr", bus.mm_addr, 32'd0);
      chk("rsvd_idx", 32'(bus.cl_idx), 32'(i));
      tick();
    end
    read_line("rsvd_line", 32'hB0, 32'd1);

    // Reset mid-fetch at idx=2, then a clean 4-word fetch
    bus.sel_cl = 2'b01; bus.we_cl = 1'b1; bus.next_cl = 1'b1;
    bus.mm_rdata = 32'hC0; tick();
    bus.mm_rdata = 32'hC1; tick();
    chk("mid_pre_idx", 32'(bus.cl_idx), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0; bus.we_cl = 1'b0; bus.next_cl = 1'b0;
    #1;
    chk("mid_idx", 32'(bus.cl_idx), 32'd0);
    chk("mid_full", 32'(bus.full_cl), 32'd0);
    read_line("mid_line", 32'd0, 32'd0);
    bus.sel_cl = 2'b01; bus.we_cl = 1'b1; bus.next_cl = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.mm_rdata = 32'hE0 + 32'(i);
      #1;
      chk("refetch_full", 32'(bus.full_cl), 32'(i == 3));
      tick();
    end
    read_line("refetch_line", 32'hE0, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
